// File: rtl/axil_csr_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one length-1 AXI-Lite access, one response out.
// Optional per-phase timeout is compiled in with `define AXIL_CSR_MASTER_TIMEOUT_EN.
module axil_csr_master #(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [2:0]  PROT           = 3'b000
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_write,
  output logic              busy,

  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_done;
  logic              w_done;
  logic [31:0]       rdata_q;
  logic [1:0]        resp_q;
  logic              write_q;
  logic              accept;
  logic              aw_hs;
  logic              w_hs;

  // Gated by rst_n so no command can be taken while reset is held.
  assign cmd_ready     = rst_n && (state == IDLE);
  assign accept        = cmd_valid && cmd_ready;
  assign busy          = (state != IDLE);
  assign rsp_valid     = (state == RSP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_write     = write_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = PROT;
  assign m_axi_arprot  = PROT;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_awvalid = (state == WR) && !aw_done;
  assign m_axi_wvalid  = (state == WR) && !w_done;
  assign m_axi_bready  = (state == WR_RESP);
  assign m_axi_arvalid = (state == RD_ADDR);
  assign m_axi_rready  = (state == RD_DATA);

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

`ifdef AXIL_CSR_MASTER_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] tcnt;
  logic        timeout_hit;
  logic        waiting;

  assign waiting = state inside {WR, WR_RESP, RD_ADDR, RD_DATA};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
`ifdef AXIL_CSR_MASTER_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE:    if (accept) state_n = cmd_write ? WR : RD_ADDR;
      WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WR_RESP;
      WR_RESP: if (m_axi_bvalid) state_n = RSP;
      RD_ADDR: if (m_axi_arready) state_n = RD_DATA;
      RD_DATA: if (m_axi_rvalid) state_n = RSP;
      RSP:     if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef AXIL_CSR_MASTER_TIMEOUT_EN
    // Only a phase that would otherwise stall another cycle can time out.
    if (waiting && (state_n == state) && (tcnt == TIMEOUT_LAST)) begin
      timeout_hit = 1'b1;
      state_n     = RSP;
    end
`endif
  end

`ifdef AXIL_CSR_MASTER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                tcnt <= '0;
    else if (state_n != state) tcnt <= '0;
    else if (waiting)          tcnt <= tcnt + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= '0;
      write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            write_q <= cmd_write;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            resp_q  <= m_axi_bresp;
            rdata_q <= '0;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            resp_q  <= m_axi_rresp;
            rdata_q <= m_axi_rdata;
          end
        end
        default: ;
      endcase
`ifdef AXIL_CSR_MASTER_TIMEOUT_EN
      if (timeout_hit) begin
        resp_q  <= 2'b11;
        rdata_q <= 32'hDEAD_BEEF;
      end
`endif
    end
  end

endmodule
